key_schedule_iter: RTL and testbench
====================================

KEY_SCHEDULE_ITER -- requirements
Module: key_schedule_iter

Interface
REQ-001 SHALL have parameter NK_MAX, default 8, meaning the largest supported key length in 32-bit words; legal values are 4, 6 and 8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a new expansion.
REQ-005 SHALL have port keylen, input, 2 bits: 0 = AES-128 (Nk 4, Nr 10), 1 = AES-192 (Nk 6, Nr 12), 2 = AES-256 (Nk 8, Nr 14), 3 = illegal.
REQ-006 SHALL have port key, input, 32*NK_MAX bits: the cipher key, most significant Nk words used, w0 = most significant word.
REQ-007 SHALL have port clear, input, 1 bit: synchronous abort.
REQ-008 SHALL have port rk, output, 128 bits: round key, word 4k in bits 127:96.
REQ-009 SHALL have port rk_idx, output, 4 bits: round number k of rk.
REQ-010 SHALL have port rk_valid, output, 1 bit, and port rk_ready, input, 1 bit: round-key handshake.
REQ-011 SHALL have ports busy, done and err, outputs, 1 bit each: status.

Function
REQ-012 SHALL implement the states IDLE, GEN and DONE.
REQ-013 SHALL accept start only in IDLE; start in GEN or DONE SHALL be ignored.
REQ-014 SHALL pulse err for one cycle and stay in IDLE when start is accepted with keylen 3 or Nk > NK_MAX.
REQ-015 SHALL capture key and keylen on the accept edge, and later changes to key or keylen SHALL have no effect.
REQ-016 SHALL drive busy high from the cycle after accept until DONE is left.
REQ-017 SHALL produce exactly one schedule word w[j] per unstalled GEN cycle, for j = 0 .. 4*Nr+3, in order.
REQ-018 SHALL take w[j] for j < Nk from the captured key.
REQ-019 SHALL compute, for j >= Nk, w[j] = w[j-Nk] XOR t, where:
- t = SubWord(RotWord(w[j-1])) XOR {rcon,24'h0} when j mod Nk = 0;
- t = SubWord(w[j-1]) when Nk = 8 and j mod Nk = 4;
- t = w[j-1] otherwise.
REQ-020 SHALL hold only the last Nk words in a sliding window register; no full-schedule storage.
REQ-021 SHALL instantiate exactly 4 S-box lookups (one SubWord per cycle), using the FIPS-197 forward S-box.
REQ-022 SHALL set rcon to 8'h01 on accept and update it to xtime(rcon) (shift left, XOR 8'h1b on carry-out) after each word with j mod Nk = 0; no rcon table.
REQ-023 SHALL assemble 4 consecutive words into rk, set rk_idx = j/4, and assert rk_valid in the cycle after the fourth word of the group.
REQ-024 SHALL keep rk, rk_idx and rk_valid stable while rk_valid=1 and rk_ready=0, and SHALL stall word generation during that time.
REQ-025 SHALL, with rk_ready held high, present round key k in cycle 4k+5 after the accept edge (cycle 0) and produce no bubbles between groups.
REQ-026 SHALL enter DONE after the handshake of rk_idx = Nr, pulse done for one cycle, drop busy, and return to IDLE.
REQ-027 SHALL make clear dominant over all other inputs: from any state, on the next edge, go to IDLE with all outputs at their reset values.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force state IDLE and set rk=0, rk_idx=0, rk_valid=0, busy=0, done=0, err=0, rcon=8'h01 and the window to 0.
REQ-029 SHALL, when rst_n asserts mid-expansion, discard the expansion, and SHALL produce no rk_valid until a new start is accepted.

Verification
REQ-030 SHALL cover: keylen=0, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> 11 round keys, rk_idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 in cycle 45, done in cycle 46.
REQ-031 SHALL cover: keylen=1, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> rk_idx 12 = e98ba06f448c773c8ecc720401002202.
REQ-032 SHALL cover: keylen=2, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> rk_idx 14 = fe4890d1e6188d0b046df344706c631e.
REQ-033 SHALL cover: AES-128 vector with rk_ready randomly low 50% of the time -> identical rk sequence, rk stable during stalls, and no lost or duplicated rk_idx.
REQ-034 SHALL cover: keylen=3, or keylen=2 with NK_MAX=4 -> one-cycle err pulse, busy=0, no rk_valid.
REQ-035 SHALL cover: clear or rst_n low at round 5, followed by a new AES-256 start -> correct full AES-256 sequence starting at rk_idx 0, and start asserted during GEN is ignored.

Source files
------------

// File: rtl/key_schedule_iter.sv
// key_schedule_iter
// Iterative AES key expansion (FIPS-197). One schedule word is produced per
// generation cycle from a sliding window holding the last Nk words. Every
// four words are packed into a 128-bit round key, which is offered through a
// valid/ready handshake.
//
// Ports
//   clk       clock, all state changes on the rising edge
//   rst_n     asynchronous active-low reset
//   start     request a new expansion (accepted only in IDLE)
//   keylen    0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = illegal
//   key       cipher key, word w0 in the most significant 32 bits
//   clear     synchronous abort, dominant over every other input
//   rk        round key, word 4k in bits 127:96
//   rk_idx    round number k of rk
//   rk_valid  rk is being offered
//   rk_ready  consumer accepts rk
//   busy      an expansion is in progress
//   done      one-cycle pulse after the last round key is taken
//   err       one-cycle pulse when start carries an unsupported keylen

module key_schedule_iter #(
   parameter int NK_MAX = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            keylen,
   input  logic [32*NK_MAX-1:0]  key,
   input  logic                  clear,
   output logic [127:0]          rk,
   output logic [3:0]            rk_idx,
   output logic                  rk_valid,
   input  logic                  rk_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

   // Forward S-box, byte 0x00 in the most significant position.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Byte x sits at bit offset 8*(255-x); 255-x is simply ~x for 8 bits.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[{~x, 3'b000} +: 8];
   endfunction

   state_t        state;
   state_t        next_state;
   logic          warm;
   logic [3:0]    nk;
   logic [3:0]    nr;
   logic [5:0]    j;
   logic [2:0]    jm;
   logic [7:0]    rcon;
   logic [31:0]   win [NK_MAX];
   logic [95:0]   group;

   logic [3:0]    nk_new;
   logic [3:0]    nr_new;
   logic          illegal;
   logic [31:0]   win_load [NK_MAX];
   logic [31:0]   old_word;
   logic [31:0]   prev_word;
   logic [31:0]   sub_in;
   logic [31:0]   sub_out;
   logic [31:0]   t;
   logic [31:0]   new_word;
   logic          key_phase;
   logic          stall;
   logic          gen_fire;
   logic          group_end;
   logic          hs;
   logic          last_hs;

   // Decode the requested key length and reject what this build cannot hold.
   always_comb begin
      case (keylen)
         2'd0:    begin nk_new = 4'd4; nr_new = 4'd10; end
         2'd1:    begin nk_new = 4'd6; nr_new = 4'd12; end
         default: begin nk_new = 4'd8; nr_new = 4'd14; end
      endcase
      illegal = (keylen == 2'd3) || (int'(nk_new) > NK_MAX);
   end

   // The key is loaded reversed (w0 at position nk-1, the "oldest" slot).
   // During the first Nk words the window just rotates the key out, so after
   // Nk steps it naturally holds w[0..Nk-1] in the right order.
   always_comb begin
      for (int p = 0; p < NK_MAX; p++) begin
         win_load[p] = '0;
         for (int q = 0; q < NK_MAX; q++) begin
            if (p + q == int'(nk_new) - 1) begin
               win_load[p] = key[32*(NK_MAX-q)-1 -: 32];
            end
         end
      end
   end

   // Next schedule word: w[j-Nk] from the oldest slot, w[j-1] from slot 0.
   // The four S-box lookups are shared between the RotWord and plain cases.
   always_comb begin
      old_word = '0;
      for (int p = 0; p < NK_MAX; p++) begin
         if (p == int'(nk) - 1) begin
            old_word = win[p];
         end
      end
      prev_word = win[0];
      key_phase = (j < {2'b00, nk});
      sub_in    = (jm == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
      sub_out   = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                   sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
      if (key_phase) begin
         t = '0;
      end else if (jm == 3'd0) begin
         t = sub_out ^ {rcon, 24'h000000};
      end else if ((nk == 4'd8) && (jm == 3'd4)) begin
         t = sub_out;
      end else begin
         t = prev_word;
      end
      new_word = old_word ^ t;
   end

   // A pending, unaccepted round key freezes generation so it cannot be
   // overwritten by the next group.
   always_comb begin
      stall     = rk_valid && !rk_ready;
      hs        = rk_valid && rk_ready;
      gen_fire  = (state == GEN) && warm && !stall && (j <= {nr, 2'b11});
      group_end = gen_fire && (j[1:0] == 2'b11);
      last_hs   = (state == GEN) && hs && (rk_idx == nr);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; clear wins over everything.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start && !illegal) next_state = GEN;
         GEN:     if (last_hs) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (clear) begin
         next_state = IDLE;
      end
   end

   // Datapath: window, counters, round-key assembly and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         warm     <= 1'b0;
         nk       <= 4'd4;
         nr       <= 4'd10;
         j        <= '0;
         jm       <= '0;
         rcon     <= 8'h01;
         group    <= '0;
         rk       <= '0;
         rk_idx   <= '0;
         rk_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         for (int p = 0; p < NK_MAX; p++) win[p] <= '0;
      end else if (clear) begin
         warm     <= 1'b0;
         nk       <= 4'd4;
         nr       <= 4'd10;
         j        <= '0;
         jm       <= '0;
         rcon     <= 8'h01;
         group    <= '0;
         rk       <= '0;
         rk_idx   <= '0;
         rk_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         for (int p = 0; p < NK_MAX; p++) win[p] <= '0;
      end else begin
         busy <= (next_state != IDLE);
         done <= (state == GEN) && (next_state == DONE);
         err  <= (state == IDLE) && start && illegal;

         if ((state == IDLE) && start && !illegal) begin
            warm     <= 1'b0;
            nk       <= nk_new;
            nr       <= nr_new;
            j        <= '0;
            jm       <= '0;
            rcon     <= 8'h01;
            rk_valid <= 1'b0;
            for (int p = 0; p < NK_MAX; p++) win[p] <= win_load[p];
         end

         if (state == GEN) begin
            warm <= 1'b1;
         end

         if (hs && !group_end) begin
            rk_valid <= 1'b0;
         end

         if (gen_fire) begin
            for (int p = NK_MAX - 1; p > 0; p--) win[p] <= win[p-1];
            win[0] <= new_word;
            j      <= j + 6'd1;
            jm     <= ({1'b0, jm} == nk - 4'd1) ? 3'd0 : jm + 3'd1;
            group  <= {group[63:0], new_word};
            // rcon advances only once it has actually been consumed, so the
            // key-copy word at j = 0 leaves it at 01 for j = Nk.
            if (!key_phase && (jm == 3'd0)) begin
               rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
            if (group_end) begin
               rk       <= {group, new_word};
               rk_idx   <= j[5:2];
               rk_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_key_schedule_iter.sv
// tb_key_schedule_iter
// Directed bench for key_schedule_iter using the FIPS-197 key expansion
// examples. Round keys are compared against hand-copied constants; timing,
// stall stability, abort behaviour and error pulses are checked as well.

module tb_key_schedule_iter;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [1:0]    keylen;
   logic [255:0]  key;
   logic          clear;
   logic [127:0]  rk;
   logic [3:0]    rk_idx;
   logic          rk_valid;
   logic          rk_ready;
   logic          busy;
   logic          done;
   logic          err;

   logic          startSmall;
   logic [127:0]  rkSmall;
   logic [3:0]    rkIdxSmall;
   logic          rkValidSmall;
   logic          busySmall;
   logic          doneSmall;
   logic          errSmall;

   int            checkCount = 0;
   int            passCount  = 0;

   logic [127:0]  expRk   [0:14];
   bit            expMask [0:14];

   always #5 clk = ~clk;

   key_schedule_iter #(.NK_MAX(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .keylen(keylen), .key(key),
      .clear(clear), .rk(rk), .rk_idx(rk_idx), .rk_valid(rk_valid),
      .rk_ready(rk_ready), .busy(busy), .done(done), .err(err)
   );

   key_schedule_iter #(.NK_MAX(4)) u_small (
      .clk(clk), .rst_n(rst_n), .start(startSmall), .keylen(keylen),
      .key(key[255:128]), .clear(clear), .rk(rkSmall), .rk_idx(rkIdxSmall),
      .rk_valid(rkValidSmall), .rk_ready(rk_ready), .busy(busySmall),
      .done(doneSmall), .err(errSmall)
   );

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
      end
   endtask

   // Loads the expected round keys of one FIPS-197 example.
   task automatic loadVector(input int sel);
      for (int i = 0; i < 15; i++) begin
         expRk[i]   = '0;
         expMask[i] = 1'b0;
      end
      if (sel == 128) begin
         expRk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
         expRk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
         expRk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
         expRk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
         expRk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
         expRk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
         expRk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
         expRk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
         expRk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
         expRk[9]  = 128'hac7766f319fadc2128d12941575c006e;
         expRk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
         for (int i = 0; i <= 10; i++) expMask[i] = 1'b1;
      end else if (sel == 192) begin
         expRk[0]   = 128'h8e73b0f7da0e6452c810f32b809079e5;
         expRk[12]  = 128'he98ba06f448c773c8ecc720401002202;
         expMask[0]  = 1'b1;
         expMask[12] = 1'b1;
      end else begin
         expRk[0]  = 128'h603deb1015ca71be2b73aef0857d7781;
         expRk[1]  = 128'h1f352c073b6108d72d9810a30914dff4;
         expRk[2]  = 128'h9ba354118e6925afa51a8b5f2067fcde;
         expRk[3]  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
         expRk[4]  = 128'hd59aecb85bf3c917fee94248de8ebe96;
         expRk[5]  = 128'hb5a9328a2678a647983122292f6c79b3;
         expRk[6]  = 128'h812c81addadf48ba24360af2fab8b464;
         expRk[7]  = 128'h98c5bfc9bebd198e268c3ba709e04214;
         expRk[8]  = 128'h68007bacb2df331696e939e46c518d80;
         expRk[9]  = 128'hc814e20476a9fb8a5025c02d59c58239;
         expRk[10] = 128'hde1369676ccc5a71fa2563959674ee15;
         expRk[11] = 128'h5886ca5d2e2f31d77e0af1fa27cf73c3;
         expRk[12] = 128'h749c47ab18501ddae2757e4f7401905a;
         expRk[13] = 128'hcafaaae3e4d59b349adf6acebd10190d;
         expRk[14] = 128'hfe4890d1e6188d0b046df344706c631e;
         for (int i = 0; i <= 14; i++) expMask[i] = 1'b1;
      end
   endtask

   // Runs one expansion and consumes its round keys.
   // abortMode: 0 none, 1 clear at round 5, 2 reset at round 5.
   task automatic applyStimulus(input logic [1:0] kl, input logic [255:0] k,
                                input int nr, input bit randomReady,
                                input int abortMode, input bit pokeStart);
      int            cyc;
      int            nextIdx;
      bit            prevStall;
      bit            finished;
      bit            sawValid;
      logic [127:0]  heldRk;
      logic [3:0]    heldIdx;

      @(negedge clk);
      keylen   = kl;
      key      = k;
      start    = 1'b1;
      rk_ready = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      key    = '1;
      keylen = 2'd3;
      checkOutput("busyAfterAccept", {127'd0, busy}, 128'd1);

      nextIdx   = 0;
      prevStall = 1'b0;
      finished  = 1'b0;
      heldRk    = '0;
      heldIdx   = '0;
      for (cyc = 0; cyc < 600 && !finished; cyc++) begin
         if (pokeStart) begin
            start  = (cyc == 8);
            keylen = (cyc == 8) ? 2'd0 : 2'd3;
         end
         if (done) begin
            checkOutput("roundCount", 128'(nextIdx), 128'(nr + 1));
            if (!randomReady) checkOutput("doneCycle", 128'(cyc), 128'(4*nr + 6));
            finished = 1'b1;
            @(negedge clk);
            checkOutput("busyAfterDone", {127'd0, busy}, 128'd0);
            checkOutput("donePulse", {127'd0, done}, 128'd0);
         end else if (rk_valid) begin
            if (prevStall) begin
               checkOutput("stallRk", rk, heldRk);
               checkOutput("stallIdx", {124'd0, rk_idx}, {124'd0, heldIdx});
            end else begin
               checkOutput("rkIdx", {124'd0, rk_idx}, 128'(nextIdx));
               if (nextIdx <= 14 && expMask[nextIdx]) begin
                  checkOutput($sformatf("rk%0d", nextIdx), rk, expRk[nextIdx]);
               end
               if (!randomReady) checkOutput("rkCycle", 128'(cyc), 128'(4*nextIdx + 5));
            end
            if (abortMode != 0 && nextIdx == 5) begin
               sawValid = 1'b0;
               if (abortMode == 1) begin
                  clear = 1'b1;
                  @(negedge clk);
                  clear = 1'b0;
                  checkOutput("clearValid", {127'd0, rk_valid}, 128'd0);
                  checkOutput("clearRk", rk, 128'd0);
               end else begin
                  rst_n = 1'b0;
                  #1;
                  checkOutput("rstValid", {127'd0, rk_valid}, 128'd0);
                  checkOutput("rstRk", rk, 128'd0);
                  @(negedge clk);
                  rst_n = 1'b1;
               end
               checkOutput("abortBusy", {127'd0, busy}, 128'd0);
               repeat (12) begin
                  @(negedge clk);
                  if (rk_valid) sawValid = 1'b1;
               end
               checkOutput("abortNoValid", {127'd0, sawValid}, 128'd0);
               return;
            end
            rk_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rk_ready) begin
               nextIdx++;
               prevStall = 1'b0;
            end else begin
               heldRk    = rk;
               heldIdx   = rk_idx;
               prevStall = 1'b1;
            end
         end else begin
            if (prevStall) checkOutput("stallDropped", 128'd0, 128'd1);
            prevStall = 1'b0;
            rk_ready  = 1'b1;
         end
         if (!finished) @(negedge clk);
      end
      start = 1'b0;
      checkOutput("finished", {127'd0, finished}, 128'd1);
   endtask

   initial begin
      bit sawValid;

      rst_n      = 1'b0;
      start      = 1'b0;
      startSmall = 1'b0;
      keylen     = 2'd0;
      key        = '0;
      clear      = 1'b0;
      rk_ready   = 1'b1;

      repeat (3) @(negedge clk);
      checkOutput("resetRk", rk, 128'd0);
      checkOutput("resetIdx", {124'd0, rk_idx}, 128'd0);
      checkOutput("resetValid", {127'd0, rk_valid}, 128'd0);
      checkOutput("resetBusy", {127'd0, busy}, 128'd0);
      checkOutput("resetDone", {127'd0, done}, 128'd0);
      checkOutput("resetErr", {127'd0, err}, 128'd0);
      rst_n = 1'b1;

      $display("[TB] AES-128, ready held high");
      loadVector(128);
      applyStimulus(2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'd0}, 10, 1'b0, 0, 1'b0);

      $display("[TB] AES-192");
      loadVector(192);
      applyStimulus(2'd1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'd0},
                    12, 1'b0, 0, 1'b0);

      $display("[TB] AES-256");
      loadVector(256);
      applyStimulus(2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                    14, 1'b0, 0, 1'b0);

      $display("[TB] AES-128 with random back-pressure");
      loadVector(128);
      applyStimulus(2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'd0}, 10, 1'b1, 0, 1'b0);

      $display("[TB] illegal key lengths");
      sawValid = 1'b0;
      @(negedge clk);
      keylen = 2'd3;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("errPulse", {127'd0, err}, 128'd1);
      checkOutput("errBusy", {127'd0, busy}, 128'd0);
      @(negedge clk);
      checkOutput("errOneCycle", {127'd0, err}, 128'd0);
      keylen     = 2'd2;
      startSmall = 1'b1;
      @(negedge clk);
      startSmall = 1'b0;
      checkOutput("smallErrPulse", {127'd0, errSmall}, 128'd1);
      checkOutput("smallErrBusy", {127'd0, busySmall}, 128'd0);
      repeat (5) begin
         @(negedge clk);
         if (rk_valid || rkValidSmall || busySmall) sawValid = 1'b1;
      end
      checkOutput("smallErrOneCycle", {127'd0, errSmall}, 128'd0);
      checkOutput("errNoValid", {127'd0, sawValid}, 128'd0);

      $display("[TB] clear at round 5, then AES-256 with stray start");
      loadVector(128);
      applyStimulus(2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'd0}, 10, 1'b0, 1, 1'b0);
      loadVector(256);
      applyStimulus(2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                    14, 1'b0, 0, 1'b1);

      $display("[TB] reset at round 5, then AES-256");
      applyStimulus(2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                    14, 1'b0, 2, 1'b0);
      applyStimulus(2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                    14, 1'b1, 0, 1'b0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
